// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit and its multiply/divide sequencer.
package alu_ctrl_pkg;

    localparam logic [1:0] AluOpRfmt   = 2'b00;
    localparam logic [1:0] AluOpBrnch  = 2'b01;
    localparam logic [1:0] AluOpOthers = 2'b10;
    localparam logic [1:0] AluOpOri    = 2'b11;

    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnSlt   = 6'b101010;
    localparam logic [5:0] FnNor   = 6'b101111;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMflo  = 6'b010010;

    localparam logic [3:0] CtlAdd = 4'b1010;
    localparam logic [3:0] CtlSub = 4'b1110;
    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlSlt = 4'b0101;
    localparam logic [3:0] CtlNor = 4'b0011;
    localparam logic [3:0] CtlMd  = 4'b1000;
    localparam logic [3:0] CtlInv = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } md_state_e;

    // Any funct that touches the sequencer or HI/LO, legal in this build or not.
    function automatic logic is_md_funct(input logic [5:0] fn);
        return (fn == FnMult) || (fn == FnMultu) || (fn == FnDiv) ||
               (fn == FnDivu) || (fn == FnMfhi)  || (fn == FnMflo);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath on operand magnitudes: shift-add multiply and
// restoring divide, one bit per step, with a down-counter flagging the last step.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_b;
    logic [CntW-1:0]  r_cnt;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH-1:0] w_div_sub;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_acc_d;
    logic [WIDTH-1:0] w_mq_d;

    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
        w_div_sh  = {r_acc, r_mq[WIDTH-1]};
        w_div_ge  = (w_div_sh >= {1'b0, r_b});
        // Difference is < r_b whenever it is kept, so the low bits are exact.
        w_div_sub = w_div_sh[WIDTH-1:0] - r_b;
        if (i_div) begin
            w_acc_d = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
            w_mq_d  = {r_mq[WIDTH-2:0], w_div_ge};
        end else begin
            w_acc_d = w_mul_sum[WIDTH:1];
            w_mq_d  = {w_mul_sum[0], r_mq[WIDTH-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc <= '0;
            r_mq  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc <= '0;
            r_mq  <= i_a;
            r_b   <= i_b;
            r_cnt <= CntW'(WIDTH - 1);
        end else if (i_step) begin
            r_acc <= w_acc_d;
            r_mq  <= w_mq_d;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == '0);
    assign o_hi   = r_acc;
    assign o_lo   = r_mq;

endmodule

// File: rtl/alu_ctrl_md.sv
// ALU control decode plus multiply/divide sequencer with HI/LO and pipeline stall.
// Signed MULT/DIV exist only when MULDIV_SIGNED_EN is defined.
module alu_ctrl_md
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       FuncCode,
    input  logic             issue,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       ALUCtl,
    output logic             ctl_illegal,
    output logic             sel_md,
    output logic [WIDTH-1:0] md_result,
    output logic             md_busy,
    output logic             stall,
    output logic             md_done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e r_state;
    md_state_e w_state_d;

    logic w_mul_op;
    logic w_div_op;
    logic w_signed_op;
    logic w_mfhi;
    logic w_mflo;
    logic w_accept;
    logic w_start;
    logic w_step;
    logic w_fix;
    logic w_last;
    logic w_div_step;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_it_hi;
    logic [WIDTH-1:0] w_it_lo;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dz_flag;
    logic             r_op_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;

    always_comb begin
        ALUCtl      = CtlInv;
        ctl_illegal = 1'b0;
        w_mul_op    = 1'b0;
        w_div_op    = 1'b0;
        w_signed_op = 1'b0;
        w_mfhi      = 1'b0;
        w_mflo      = 1'b0;
        case (ALUOp)
            AluOpRfmt: begin
                case (FuncCode)
                    FnAdd:   ALUCtl = CtlAdd;
                    FnSub:   ALUCtl = CtlSub;
                    FnAnd:   ALUCtl = CtlAnd;
                    FnOr:    ALUCtl = CtlOr;
                    FnSlt:   ALUCtl = CtlSlt;
                    FnNor:   ALUCtl = CtlNor;
                    FnMultu: begin
                        ALUCtl   = CtlMd;
                        w_mul_op = 1'b1;
                    end
                    FnDivu: begin
                        ALUCtl   = CtlMd;
                        w_div_op = 1'b1;
                    end
                    FnMfhi: begin
                        ALUCtl = CtlMd;
                        w_mfhi = 1'b1;
                    end
                    FnMflo: begin
                        ALUCtl = CtlMd;
                        w_mflo = 1'b1;
                    end
`ifdef MULDIV_SIGNED_EN
                    FnMult: begin
                        ALUCtl      = CtlMd;
                        w_mul_op    = 1'b1;
                        w_signed_op = 1'b1;
                    end
                    FnDiv: begin
                        ALUCtl      = CtlMd;
                        w_div_op    = 1'b1;
                        w_signed_op = 1'b1;
                    end
`endif
                    default: begin
                        ALUCtl      = CtlInv;
                        ctl_illegal = 1'b1;
                    end
                endcase
            end
            AluOpBrnch:  ALUCtl = CtlSub;
            AluOpOthers: ALUCtl = CtlAdd;
            default:     ALUCtl = CtlOr;
        endcase
    end

    assign sel_md    = w_mfhi | w_mflo;
    assign md_result = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);
    assign md_busy   = (r_state != StIdle);
    assign stall     = issue && md_busy && is_md_funct(FuncCode);
    assign w_accept  = issue && (w_mul_op || w_div_op) && !stall;

    // Sequencer runs on magnitudes; signs are remembered and reapplied in StFix.
    assign w_a_neg = w_signed_op & src_a[WIDTH-1];
    assign w_b_neg = w_signed_op & src_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -src_a : src_a;
    assign w_b_mag = w_b_neg ? -src_b : src_b;

    always_comb begin
        w_state_d = r_state;
        w_start   = 1'b0;
        w_step    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_start = 1'b1;
                    if (w_div_op) begin
                        w_state_d = StDiv;
                    end else begin
                        w_state_d = StMul;
                    end
                end
            end
            StMul, StDiv: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_d = StFix;
                end
            end
            StFix:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign w_fix      = (r_state == StFix);
    assign w_div_step = (r_state == StDiv);

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .i_clk   (clk),
        .i_reset (reset),
        .i_start (w_start),
        .i_step  (w_step),
        .i_div   (w_div_step),
        .i_a     (w_a_mag),
        .i_b     (w_b_mag),
        .o_last  (w_last),
        .o_hi    (w_it_hi),
        .o_lo    (w_it_lo)
    );

    // Zero divisor leaves |dividend| as remainder; quotient is forced to all ones.
    assign w_prod     = {w_it_hi, w_it_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_dz ? '1 : (r_neg_q ? -w_it_lo : w_it_lo);
    assign w_rem_fix  = r_neg_r ? -w_it_hi : w_it_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dz_flag <= 1'b0;
            r_op_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_done    <= w_fix;
            r_dz_flag <= w_fix && r_op_div && r_dz;
            if (w_start) begin
                r_op_div <= w_div_op;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_dz     <= (src_b == '0);
            end
            if (w_fix) begin
                if (r_op_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign md_done     = r_done;
    assign div_by_zero = r_dz_flag;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Randomised bench for alu_ctrl_md against a cycle-level behavioural model,
// plus directed cases with hand-computed results.
module tb_alu_ctrl_md;

    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    ALUOp;
    logic [5:0]    FuncCode;
    logic          issue;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [3:0]    ALUCtl;
    logic          ctl_illegal;
    logic          sel_md;
    logic [W-1:0]  md_result;
    logic          md_busy;
    logic          stall;
    logic          md_done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    alu_ctrl_md #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ALUOp       (ALUOp),
        .FuncCode    (FuncCode),
        .issue       (issue),
        .src_a       (src_a),
        .src_b       (src_b),
        .ALUCtl      (ALUCtl),
        .ctl_illegal (ctl_illegal),
        .sel_md      (sel_md),
        .md_result   (md_result),
        .md_busy     (md_busy),
        .stall       (stall),
        .md_done     (md_done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    logic [5:0] tab_fn [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b101111, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
                                6'b010000, 6'b010010};
    logic [3:0] tab_ctl [12] = '{4'b1010, 4'b1110, 4'b0000, 4'b0001, 4'b0101, 4'b0011,
                                 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    bit tab_sgn [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};

    int n_total = 0;
    int n_bad   = 0;

    // Model state: architectural HI/LO plus one pending result and the edge it lands on.
    bit          m_valid = 1'b0;
    bit          m_pending;
    int          m_edge = 0;
    int          m_done_edge;
    logic [64:0] m_res;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    bit          m_done;
    bit          m_dz;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_md_fn(input logic [5:0] fn);
        for (int k = 6; k < 12; k++) begin
            if (fn == tab_fn[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit is_start(input logic [1:0] op, input logic [5:0] fn);
        if (op != 2'b00) return 1'b0;
        if (fn == F_MULTU || fn == F_DIVU) return 1'b1;
        return SIGNED_EN && (fn == F_MULT || fn == F_DIV);
    endfunction

    // {illegal, ALUCtl}
    function automatic logic [4:0] exp_ctl(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b01) return 5'b0_1110;
        if (op == 2'b10) return 5'b0_1010;
        if (op == 2'b11) return 5'b0_0001;
        for (int k = 0; k < 12; k++) begin
            if (fn == tab_fn[k] && (SIGNED_EN || !tab_sgn[k])) return {1'b0, tab_ctl[k]};
        end
        return 5'b1_1111;
    endfunction

    // {div_by_zero, hi, lo}
    function automatic logic [64:0] md_compute(input logic [5:0] fn, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [63:0] p;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (fn == F_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            return {1'b0, p};
        end
        if (fn == F_MULT) begin
            p = sa * sb;
            return {1'b0, p};
        end
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (fn == F_DIVU) return {1'b0, a % b, a / b};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic compare();
        logic [4:0] ce;
        bit mfhi;
        bit mflo;
        ce   = exp_ctl(ALUOp, FuncCode);
        mfhi = (ALUOp == 2'b00) && (FuncCode == F_MFHI);
        mflo = (ALUOp == 2'b00) && (FuncCode == F_MFLO);
        chk("ALUCtl", ALUCtl, ce[3:0]);
        chk("ctl_illegal", ctl_illegal, ce[4]);
        chk("sel_md", sel_md, mfhi || mflo);
        chk("md_result", md_result, mfhi ? m_hi : (mflo ? m_lo : 32'd0));
        chk("md_busy", md_busy, m_pending);
        chk("stall", stall, issue && m_pending && is_md_fn(FuncCode));
        chk("md_done", md_done, m_done);
        chk("div_by_zero", div_by_zero, m_dz);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic model_edge();
        m_edge++;
        m_done = 1'b0;
        m_dz   = 1'b0;
        if (reset) begin
            m_valid   = 1'b1;
            m_pending = 1'b0;
            m_hi      = '0;
            m_lo      = '0;
        end else if (m_valid) begin
            if (m_pending) begin
                if (m_edge == m_done_edge) begin
                    {m_dz, m_hi, m_lo} = m_res;
                    m_done    = 1'b1;
                    m_pending = 1'b0;
                end
            end else if (issue && is_start(ALUOp, FuncCode)) begin
                m_pending   = 1'b1;
                m_done_edge = m_edge + W + 1;
                m_res       = md_compute(FuncCode, src_a, src_b);
            end
        end
    endtask

    // One clock: drive at the falling edge, check settled outputs, then advance the model.
    task automatic cyc(input bit rst, input bit iss, input logic [1:0] op,
                       input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        reset    = rst;
        issue    = iss;
        ALUOp    = op;
        FuncCode = fn;
        src_a    = a;
        src_b    = b;
        #1;
        if (m_valid) compare();
        model_edge();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'b00, F_ADD, '0, '0);
    endtask

    // Returns the number of cycles after the accept edge at which md_done is seen.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (md_done) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int cnt;
        logic [5:0] fn;
        logic [1:0] op;

        reset = 1'b1; issue = 1'b0; ALUOp = '0; FuncCode = '0; src_a = '0; src_b = '0;
        cyc(1'b1, 1'b0, 2'b00, F_ADD, '0, '0);
        cyc(1'b1, 1'b0, 2'b00, F_ADD, '0, '0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", md_busy, 0);
        chk("reset_done", md_done, 0);
        idle();

        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 12; k++) begin
                cyc(1'b0, 1'b0, 2'(o), tab_fn[k], '0, '0);
            end
        end
        cyc(1'b0, 1'b0, 2'b00, 6'b000111, '0, '0);
        chk("dec_inv_ctl", ALUCtl, 4'b1111);
        chk("dec_inv_illegal", ctl_illegal, 1);
        cyc(1'b0, 1'b0, 2'b01, F_ADD, '0, '0);
        chk("dec_brnch", ALUCtl, 4'b1110);
        cyc(1'b0, 1'b0, 2'b11, 6'b000111, '0, '0);
        chk("dec_ori", ALUCtl, 4'b0001);
        cyc(1'b0, 1'b0, 2'b00, F_ADD, '0, '0);
        chk("dec_add", ALUCtl, 4'b1010);

        cyc(1'b0, 1'b1, 2'b00, F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(lat);
        chk("multu_latency", lat, 33);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        cyc(1'b0, 1'b1, 2'b00, F_DIVU, 32'd100, 32'd7);
        wait_done(lat);
        chk("divu_latency", lat, 33);
        chk("divu_lo", lo, 14);
        chk("divu_hi", hi, 2);
        chk("divu_dz", div_by_zero, 0);

        cyc(1'b0, 1'b1, 2'b00, F_DIVU, 32'd5, 32'd0);
        wait_done(lat);
        chk("divz_hi", hi, 5);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_flag", div_by_zero, 1);

`ifdef MULDIV_SIGNED_EN
        cyc(1'b0, 1'b1, 2'b00, F_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat);
        chk("mult_lat", lat, 33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        cyc(1'b0, 1'b1, 2'b00, F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
`endif

        // MFLO arriving five cycles into a multiply waits for the result.
        cyc(1'b0, 1'b1, 2'b00, F_MULTU, 32'h1234_5678, 32'h0000_0010);
        repeat (4) idle();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b1, 2'b00, F_MFLO, '0, '0);
            if (!stall) break;
            cnt++;
        end
        chk("mflo_stall_cycles", cnt, 29);
        chk("mflo_done", md_done, 1);
        chk("mflo_result", md_result, 32'h2345_6780);

        // ADD runs freely while busy; MULTU held until the done cycle is then accepted.
        cyc(1'b0, 1'b1, 2'b00, F_MULTU, 32'd7, 32'd9);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 2'b00, F_ADD, 32'd1, 32'd2);
            chk("add_no_stall", stall, 0);
            chk("add_busy", md_busy, 1);
        end
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b1, 2'b00, F_MULTU, 32'd3, 32'd4);
            if (md_done) break;
            cnt++;
        end
        chk("b2b_wait", cnt, 30);
        chk("b2b_no_stall", stall, 0);
        chk("b2b_first_lo", lo, 63);
        idle();
        chk("b2b_accepted", md_busy, 1);
        wait_done(lat);
        chk("b2b_lat", lat, 32);
        chk("b2b_second_lo", lo, 12);

        // Reset mid-divide discards the operation.
        cyc(1'b0, 1'b1, 2'b00, F_DIVU, 32'd1000, 32'd3);
        repeat (9) idle();
        cyc(1'b1, 1'b0, 2'b00, F_ADD, '0, '0);
        idle();
        chk("rst_mid_busy", md_busy, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (md_done) cnt++;
        end
        chk("rst_mid_no_done", cnt, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) < 12) begin
                fn = tab_fn[$urandom_range(0, 11)];
            end else begin
                fn = 6'($urandom);
            end
            op = 2'($urandom_range(0, 3));
            if (is_md_fn(fn)) op = 2'b00;
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, op, fn,
                rand_opnd(), rand_opnd());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
